traffic_light_monitor: RTL

- Receive-side checker for the UK traffic-light sequence.
- Samples the red/amber/green lines driven by the light sequencer.
- Decodes the current phase, locks onto the legal R -> R+A -> G -> A -> R cycle and counts completed cycles and dwell time.
- Raises sticky error flags for illegal light patterns and out-of-order transitions. Sits beside the sequencer on the same clock, as a self-check/observability block.

---
 rtl/traffic_light_monitor.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the UK R -> R+A -> G -> A traffic-light sequence.
// Optional dwell timeout flag enabled by defining TLM_DWELL_TIMEOUT_EN.
module traffic_light_monitor #(
  parameter int CNT_W     = 8,
  parameter int DWELL_W   = 8,
  parameter int MAX_DWELL = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               red,
  input  logic               amber,
  input  logic               green,
  input  logic               clr_err,
  output logic               locked,
  output logic [1:0]         phase,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [DWELL_W-1:0] dwell_cnt,
  output logic               err_illegal,
  output logic               err_seq,
  output logic               err_timeout
);

  if (MAX_DWELL < 1 || MAX_DWELL > (2 ** DWELL_W) - 2) begin : g_bad_max_dwell
    $error("traffic_light_monitor: MAX_DWELL out of range");
  end

  typedef enum logic [2:0] {S_SYNC, S_RED, S_RED_AMBER, S_GREEN, S_AMBER} state_t;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [DWELL_W-1:0] sat_inc_dwell(input logic [DWELL_W-1:0] v);
    return (&v) ? v : v + DWELL_W'(1);
  endfunction

  function automatic state_t succ(input state_t s);
    case (s)
      S_RED:       return S_RED_AMBER;
      S_RED_AMBER: return S_GREEN;
      S_GREEN:     return S_AMBER;
      default:     return S_RED;
    endcase
  endfunction

  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      S_RED_AMBER: return 2'd1;
      S_GREEN:     return 2'd2;
      S_AMBER:     return 2'd3;
      default:     return 2'd0;
    endcase
  endfunction

  state_t               r_state;
  logic [1:0]           r_phase;
  logic [CNT_W-1:0]     r_cycle;
  logic [DWELL_W-1:0]   r_dwell;
  logic                 r_err_illegal;
  logic                 r_err_seq;

  state_t               w_state_nxt;
  state_t               w_pat_state;
  logic                 w_legal;
  logic [1:0]           w_phase_nxt;
  logic [CNT_W-1:0]     w_cycle_nxt;
  logic [DWELL_W-1:0]   w_dwell_nxt;
  logic                 w_ev_illegal;
  logic                 w_ev_seq;
`ifdef TLM_DWELL_TIMEOUT_EN
  logic                 w_ev_timeout;
  logic                 r_err_timeout;
`endif

  always_comb begin
    w_legal     = 1'b1;
    w_pat_state = S_SYNC;
    case ({red, amber, green})
      3'b100:  w_pat_state = S_RED;
      3'b110:  w_pat_state = S_RED_AMBER;
      3'b001:  w_pat_state = S_GREEN;
      3'b010:  w_pat_state = S_AMBER;
      default: w_legal     = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_cycle_nxt  = r_cycle;
    w_dwell_nxt  = r_dwell;
    w_ev_illegal = 1'b0;
    w_ev_seq     = 1'b0;
`ifdef TLM_DWELL_TIMEOUT_EN
    w_ev_timeout = 1'b0;
`endif
    if (!w_legal) begin
      // Phase deliberately holds its last value while unlocked.
      w_ev_illegal = 1'b1;
      w_state_nxt  = S_SYNC;
      w_dwell_nxt  = '0;
    end else if (r_state == S_SYNC) begin
      w_state_nxt = w_pat_state;
      w_phase_nxt = phase_of(w_pat_state);
      w_dwell_nxt = '0;
    end else if (w_pat_state == r_state) begin
      w_dwell_nxt = sat_inc_dwell(r_dwell);
`ifdef TLM_DWELL_TIMEOUT_EN
      w_ev_timeout = (r_dwell == DWELL_W'(MAX_DWELL - 1));
`endif
    end else if (w_pat_state == succ(r_state)) begin
      w_state_nxt = w_pat_state;
      w_phase_nxt = phase_of(w_pat_state);
      w_dwell_nxt = '0;
      if (r_state == S_AMBER) w_cycle_nxt = sat_inc_cnt(r_cycle);
    end else begin
      w_ev_seq    = 1'b1;
      w_state_nxt = w_pat_state;
      w_phase_nxt = phase_of(w_pat_state);
      w_dwell_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_SYNC;
    else     r_state <= w_state_nxt;
  end

  // A new error event on the same edge as clr_err takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase       <= '0;
      r_cycle       <= '0;
      r_dwell       <= '0;
      r_err_illegal <= 1'b0;
      r_err_seq     <= 1'b0;
    end else begin
      r_phase       <= w_phase_nxt;
      r_cycle       <= w_cycle_nxt;
      r_dwell       <= w_dwell_nxt;
      r_err_illegal <= w_ev_illegal | (r_err_illegal & ~clr_err);
      r_err_seq     <= w_ev_seq     | (r_err_seq     & ~clr_err);
    end
  end

`ifdef TLM_DWELL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) r_err_timeout <= 1'b0;
    else     r_err_timeout <= w_ev_timeout | (r_err_timeout & ~clr_err);
  end
  assign err_timeout = r_err_timeout;
`else
  assign err_timeout = 1'b0;
`endif

  assign locked      = (r_state != S_SYNC);
  assign phase       = r_phase;
  assign cycle_cnt   = r_cycle;
  assign dwell_cnt   = r_dwell;
  assign err_illegal = r_err_illegal;
  assign err_seq     = r_err_seq;

endmodule
